// File: rtl/vec_issue_ctrl.sv
// Vector issue stage: instruction FIFO feeding a single active op that is broadcast to all lanes,
// with start pulse, sticky per-lane done collection, and a watchdog that forces an error retire.
module vec_issue_ctrl #(
    parameter int lanes_p    = 4,
    parameter int els_p      = 8,
    parameter int vdw_p      = 8,
    parameter int op_width_p = 4,
    parameter int fifo_els_p = 2,
    parameter int timeout_p  = 255,
    localparam int addr_w_lp  = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int timer_w_lp = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [op_width_p-1:0]    op_i,
    input  logic [addr_w_lp-1:0]     rs1_i,
    input  logic [addr_w_lp-1:0]     rs2_i,
    input  logic [addr_w_lp-1:0]     rd_i,
    input  logic [vdw_p-1:0]         scalar_i,
    input  logic [lanes_p*vdw_p-1:0] w_data_i,
    output logic [op_width_p-1:0]    op_o,
    output logic                     start_o,
    output logic [vdw_p-1:0]         scalar_o,
    output logic [lanes_p*vdw_p-1:0] w_data_o,
    output logic [addr_w_lp-1:0]     rs1_o,
    output logic [addr_w_lp-1:0]     rs2_o,
    output logic [addr_w_lp-1:0]     rd_o,
    input  logic [lanes_p-1:0]       done_i,
    output logic                     busy_o,
    output logic                     done_v_o,
    output logic                     err_o,
    output logic [1:0]               state_o
);

    // Handshake: an instruction is accepted on a cycle where v_i && ready_o; ready_o depends only on
    // FIFO occupancy. The FIFO head stays resident until its op retires.
    localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

    typedef struct packed {
        logic [op_width_p-1:0]    op;
        logic [addr_w_lp-1:0]     rs1;
        logic [addr_w_lp-1:0]     rs2;
        logic [addr_w_lp-1:0]     rd;
        logic [vdw_p-1:0]         scalar;
        logic [lanes_p*vdw_p-1:0] w_data;
    } instr_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETIRE} state_e;

    state_e                state_r, state_n;
    instr_t                mem_r [fifo_els_p];
    instr_t                active_r;
    logic [ptr_w_lp-1:0]   wr_ptr_r, rd_ptr_r;
    logic [cnt_w_lp-1:0]   count_r;
    logic [lanes_p-1:0]    sticky_r;
    logic [timer_w_lp-1:0] timer_r;
    logic                  err_r;
    logic                  full, empty, push, pop, all_done, timeout_hit;

    assign full        = (count_r == cnt_w_lp'(fifo_els_p));
    assign empty       = (count_r == '0);
    assign push        = v_i & ~full;
    assign pop         = (state_r == RETIRE);
    assign all_done    = &(sticky_r | done_i);
    assign timeout_hit = (timer_r == timer_w_lp'(timeout_p));

    always_ff @(posedge clk_i) begin
        if (push) mem_r[wr_ptr_r] <= instr_t'{op_i, rs1_i, rs2_i, rd_i, scalar_i, w_data_i};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(fifo_els_p - 1)) ? '0 : wr_ptr_r + ptr_w_lp'(1);
            if (pop)  rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(fifo_els_p - 1)) ? '0 : rd_ptr_r + ptr_w_lp'(1);
            case ({push, pop})
                2'b10:   count_r <= count_r + cnt_w_lp'(1);
                2'b01:   count_r <= count_r - cnt_w_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= IDLE;
            active_r <= '0;
            sticky_r <= '0;
            timer_r  <= '0;
            err_r    <= 1'b0;
        end else begin
            state_r <= state_n;
            if (state_r == IDLE && !empty) active_r <= mem_r[rd_ptr_r];
            if (state_r == ISSUE) begin
                sticky_r <= '0;
                timer_r  <= '0;
            end
            // err_r keeps the value from the final WAIT cycle, which decides the retire reason.
            if (state_r == WAIT) begin
                sticky_r <= sticky_r | done_i;
                timer_r  <= timer_r + timer_w_lp'(1);
                err_r    <= ~all_done;
            end
        end
    end

    always_comb begin
        state_n  = state_r;
        start_o  = 1'b0;
        done_v_o = 1'b0;
        err_o    = 1'b0;
        case (state_r)
            IDLE:   if (!empty) state_n = ISSUE;
            ISSUE: begin
                start_o = 1'b1;
                state_n = WAIT;
            end
            WAIT:   if (all_done || timeout_hit) state_n = RETIRE;
            RETIRE: begin
                done_v_o = 1'b1;
                err_o    = err_r;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign ready_o  = ~full;
    assign busy_o   = (state_r != IDLE);
    assign state_o  = state_r;
    assign op_o     = active_r.op;
    assign rs1_o    = active_r.rs1;
    assign rs2_o    = active_r.rs2;
    assign rd_o     = active_r.rd;
    assign scalar_o = active_r.scalar;
    assign w_data_o = active_r.w_data;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Randomized bench for vec_issue_ctrl against a timeline model: each accepted instruction gets a
// start cycle from its push cycle and the previous retire, and a retire cycle from observed lane dones.
module tb_vec_issue_ctrl;

    localparam int INSTR_W = 4 + 3 + 3 + 3 + 8 + 32;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic        ready_o;
    logic [3:0]  op_i;
    logic [2:0]  rs1_i, rs2_i, rd_i;
    logic [7:0]  scalar_i;
    logic [31:0] w_data_i;
    logic [3:0]  op_o;
    logic        start_o;
    logic [7:0]  scalar_o;
    logic [31:0] w_data_o;
    logic [2:0]  rs1_o, rs2_o, rd_o;
    logic [3:0]  done_i;
    logic        busy_o, done_v_o, err_o;
    logic [1:0]  state_o;

    vec_issue_ctrl dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
        .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .scalar_i(scalar_i), .w_data_i(w_data_i),
        .op_o(op_o), .start_o(start_o), .scalar_o(scalar_o), .w_data_o(w_data_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .done_i(done_i), .busy_o(busy_o), .done_v_o(done_v_o), .err_o(err_o),
        .state_o(state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    logic [INSTR_W-1:0] exp_q[$];
    int                 push_cyc_q[$];
    logic [INSTR_W-1:0] last_ins;
    int                 occ, last_dv, start_c, dv_c, n_retired, n_err;
    bit                 act, m_err;
    logic [3:0]         seen;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        push_cyc_q.delete();
        last_ins = '0;
        occ      = 0;
        last_dv  = -100;
        act      = 1'b0;
        seen     = '0;
        dv_c     = -1;
        m_err    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"},  busy_o,   1'b0);
        check_eq({tag, "_start"}, start_o,  1'b0);
        check_eq({tag, "_dv"},    done_v_o, 1'b0);
        check_eq({tag, "_err"},   err_o,    1'b0);
        check_eq({tag, "_op"},    op_o,     4'd0);
        check_eq({tag, "_rd"},    rd_o,     3'd0);
        check_eq({tag, "_wd"},    w_data_o, 32'd0);
    endtask

    // Reset is raised between clock edges; outputs must clear without waiting for an edge.
    task automatic apply_reset(input string tag);
        v_i     = 1'b0;
        done_i  = '0;
        reset_i = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs({tag, "_held"});
        reset_i = 1'b0;
        model_clear();
    endtask

    // driver: one cycle of random stimulus, then check against the model at the falling edge
    task automatic run_cycle(input bit allow_v, input logic [3:0] done_mask);
        logic [INSTR_W-1:0] ins;
        int                 avail;
        bit                 exp_start, exp_dv, exp_err, exp_ready;
        @(posedge clk_i);
        cyc++;
        #1;
        v_i      = allow_v && ($urandom_range(0, 2) == 0);
        op_i     = 4'($urandom_range(0, 15));
        rs1_i    = 3'($urandom_range(0, 7));
        rs2_i    = 3'($urandom_range(0, 7));
        rd_i     = 3'($urandom_range(0, 7));
        scalar_i = 8'($urandom_range(0, 255));
        w_data_i = $urandom;
        done_i   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & done_mask;
        @(negedge clk_i);

        exp_start = 1'b0;
        exp_dv    = 1'b0;
        exp_err   = 1'b0;
        if (!act && exp_q.size() > 0) begin
            avail = (push_cyc_q[0] + 1 > last_dv + 1) ? push_cyc_q[0] + 1 : last_dv + 1;
            if (cyc == avail + 1) begin
                act       = 1'b1;
                last_ins  = exp_q.pop_front();
                void'(push_cyc_q.pop_front());
                start_c   = cyc;
                seen      = '0;
                dv_c      = -1;
                exp_start = 1'b1;
            end
        end
        if (act && cyc > start_c && dv_c < 0) begin
            seen = seen | done_i;
            if (seen == 4'hf) begin
                dv_c  = cyc + 1;
                m_err = 1'b0;
            end else if (cyc == start_c + 256) begin
                dv_c  = cyc + 1;
                m_err = 1'b1;
            end
        end
        if (act && cyc == dv_c) begin
            exp_dv  = 1'b1;
            exp_err = m_err;
        end
        exp_ready = (occ < 2);

        check_eq("start_o",  start_o,  exp_start);
        check_eq("done_v_o", done_v_o, exp_dv);
        check_eq("err_o",    err_o,    exp_err);
        check_eq("busy_o",   busy_o,   act);
        check_eq("ready_o",  ready_o,  exp_ready);
        ins = {op_o, rs1_o, rs2_o, rd_o, scalar_o, w_data_o};
        check_eq("active_fields", ins, last_ins);

        if (exp_dv) begin
            act     = 1'b0;
            last_dv = cyc;
            occ--;
            n_retired++;
            if (exp_err) n_err++;
        end
        if (v_i && exp_ready) begin
            exp_q.push_back({op_i, rs1_i, rs2_i, rd_i, scalar_i, w_data_i});
            push_cyc_q.push_back(cyc);
            occ++;
        end
    endtask

    initial begin
        int waited;
        n_retired = 0;
        n_err     = 0;
        model_clear();
        v_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
        scalar_i = '0; w_data_i = '0; done_i = '0;
        reset_i = 1'b1;
        #1;
        check_reset_outputs("por");
        @(posedge clk_i);
        @(negedge clk_i);
        apply_reset("rst0");

        // mixed traffic with random, staggered and out-of-window lane dones
        for (int i = 0; i < 1500; i++) run_cycle(1'b1, 4'hf);
        check_eq("retired_some", (n_retired > 20), 1'b1);

        // lane 2 silent: ops must retire through the watchdog with err_o
        for (int i = 0; i < 900; i++) run_cycle(1'b1, 4'b1011);
        check_eq("timeouts_seen", (n_err >= 2), 1'b1);

        // lane 2 back: drain queue and make sure the next op retires cleanly
        for (int i = 0; i < 700; i++) run_cycle(i < 200, 4'hf);
        check_eq("drained", (exp_q.size() == 0 && !act), 1'b1);

        // reset while an op sits in WAIT with more queued behind it
        waited = 0;
        while (!(act && cyc > start_c && dv_c < 0 && exp_q.size() > 0) && waited < 300) begin
            run_cycle(1'b1, 4'b0001);
            waited++;
        end
        check_eq("reached_wait", (waited < 300), 1'b1);
        apply_reset("rst_wait");
        // queued instructions must be gone: nothing may issue without new pushes
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 4'hf);
        check_eq("occ_after_reset", ready_o, 1'b1);

        for (int i = 0; i < 300; i++) run_cycle(1'b1, 4'hf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
